// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and defaults for the UART transmit arbiter and its round-robin picker.
package uart_pkg;

    typedef enum logic [1:0] {IDLE, SEND, LOAD, WAIT} arb_state_e;

    localparam int DEF_NUM_REQ     = 4;
    localparam int DEF_DATA_W      = 8;
    localparam int DEF_TIMEOUT_CYC = 65535;

    // Index width that never collapses to zero bits for tiny counts.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester byte streams plus the transmitter load/done handshake.
// master is the arbiter's view; slave is the requesters/transmitter view.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_last;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      uart_write_en;
    logic [DATA_W-1:0]         uart_data;
    logic                      uart_busy;
    logic                      uart_done;

    modport master (
        input  req_valid, req_data, req_last, uart_busy, uart_done,
        output req_ready, uart_write_en, uart_data
    );

    modport slave (
        output req_valid, req_data, req_last, uart_busy, uart_done,
        input  req_ready, uart_write_en, uart_data
    );
endinterface

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// Combinational rotate-priority pick: first set request after ptr, wrapping modulo N.
module rr_arbiter
    import uart_pkg::*;
#(
    parameter int N = DEF_NUM_REQ
)(
    input  logic [N-1:0]              req,
    input  logic [idx_width(N)-1:0]   ptr,
    output logic                      any,
    output logic [idx_width(N)-1:0]   winner
);
    localparam int W = idx_width(N);

    int          idx;
    logic [W-1:0] sel;

    always_comb begin
        any    = 1'b0;
        winner = '0;
        idx    = 0;
        sel    = '0;
        for (int off = 1; off <= N; off++) begin
            idx = (int'(ptr) + off) % N;
            sel = W'(idx);
            if (!any && req[sel]) begin
                any    = 1'b1;
                winner = sel;
            end
        end
    end
endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin owner of a single UART transmitter; holds the grant for a whole packet
// and releases it through a watchdog if the owner or the transmitter stalls.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ     = DEF_NUM_REQ,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
)(
    input  logic                           clk,
    input  logic                           rst,
    uart_tx_arbiter_if.master              bus,
    output logic [idx_width(NUM_REQ)-1:0]  grant_id,
    output logic                           busy,
    output logic                           timeout_err,
    input  logic                           err_clr
);
    localparam int IDX_W = idx_width(NUM_REQ);
    localparam int WD_W  = idx_width(TIMEOUT_CYC);

    arb_state_e        state, state_nx;
    logic [IDX_W-1:0]  rr_ptr, win;
    logic              any;
    logic [DATA_W-1:0] data_q;
    logic              last_q;
    logic [WD_W-1:0]   wd_cnt;
    logic              hs, wd_exp, to_set;
    logic              own_valid, own_last;
    logic [DATA_W-1:0] data_arr [NUM_REQ];
    logic [NUM_REQ-1:0] ready;
    logic              write_en;
    logic [DATA_W-1:0] tx_data;

    rr_arbiter #(.N(NUM_REQ)) u_pick (
        .req    (bus.req_valid),
        .ptr    (rr_ptr),
        .any    (any),
        .winner (win)
    );

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) data_arr[i] = bus.req_data[i*DATA_W +: DATA_W];
    end

    assign own_valid = bus.req_valid[grant_id];
    assign own_last  = bus.req_last[grant_id];
    assign wd_exp    = (wd_cnt == WD_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            grant_id    <= '0;
            rr_ptr      <= IDX_W'(NUM_REQ - 1);
            data_q      <= '0;
            last_q      <= 1'b0;
            wd_cnt      <= '0;
            timeout_err <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == IDLE && state_nx == SEND) grant_id <= win;
            if (hs) begin
                data_q <= data_arr[grant_id];
                last_q <= own_last;
            end
            if ((state == WAIT && bus.uart_done && last_q) || to_set) rr_ptr <= grant_id;
            // Counter restarts on every entry to SEND/WAIT, including WAIT->SEND mid-packet.
            if (state_nx != state && (state_nx == SEND || state_nx == WAIT))
                wd_cnt <= '0;
            else if (state == SEND || state == WAIT)
                wd_cnt <= wd_cnt + WD_W'(1);
            else
                wd_cnt <= '0;
            if (to_set)       timeout_err <= 1'b1;
            else if (err_clr) timeout_err <= 1'b0;
        end
    end

    always_comb begin
        state_nx = state;
        ready    = '0;
        write_en = 1'b0;
        tx_data  = '0;
        hs       = 1'b0;
        to_set   = 1'b0;
        case (state)
            IDLE: if (any && !bus.uart_busy) state_nx = SEND;
            SEND: begin
                ready[grant_id] = own_valid;
                hs = own_valid;
                if (hs) state_nx = LOAD;
                else if (wd_exp) begin
                    to_set   = 1'b1;
                    state_nx = IDLE;
                end
            end
            LOAD: begin
                write_en = 1'b1;
                tx_data  = data_q;
                state_nx = WAIT;
            end
            WAIT: begin
                // done takes priority over a watchdog expiry in the same cycle
                if (bus.uart_done) state_nx = last_q ? IDLE : SEND;
                else if (wd_exp) begin
                    to_set   = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign bus.req_ready     = ready;
    assign bus.uart_write_en = write_en;
    assign bus.uart_data     = tx_data;
    assign busy              = (state != IDLE);
endmodule
